// File: rtl/decap_ekey_lookup.sv
// Decap ekey lookup engine: hashes a key into both ekey hash tables, matches bucket entries,
// reads the matching value and writes back word 0 with its saturating hit counter bumped.
`ifndef EKEY_HASH_TABLE_DEPTH_NBITS
`define EKEY_HASH_TABLE_DEPTH_NBITS 8
`endif
`ifndef EKEY_VALUE_DEPTH_NBITS
`define EKEY_VALUE_DEPTH_NBITS 10
`endif
`ifndef EKEY_VALUE_NBITS
`define EKEY_VALUE_NBITS 128
`endif
`ifndef RESET_SIG
`define RESET_SIG rst_n
`endif

module decap_ekey_lookup #(
  parameter int KEY_NBITS         = 64,
  parameter int DEPTH_NBITS       = `EKEY_HASH_TABLE_DEPTH_NBITS,
  parameter int VALUE_DEPTH_NBITS = `EKEY_VALUE_DEPTH_NBITS,
  parameter int ENTRY_NBITS       = 1 + KEY_NBITS + VALUE_DEPTH_NBITS,
  parameter int BUCKET_NBITS      = 2 * ENTRY_NBITS,
  parameter int VALUE_NBITS       = `EKEY_VALUE_NBITS,
  parameter int WM_NBITS          = 64
) (
  input  logic                         clk,
  input  logic                         `RESET_SIG,

  input  logic                         req_valid,
  input  logic [KEY_NBITS-1:0]         req_key,
  output logic                         req_ready,

  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic                         resp_hit,
  output logic [VALUE_DEPTH_NBITS-1:0] resp_ptr,
  output logic [VALUE_NBITS-1:0]       resp_value,

  output logic                         ekey_hash_table0_rd,
  output logic [DEPTH_NBITS-1:0]       ekey_hash_table0_raddr,
  input  logic                         ekey_hash_table0_ack,
  input  logic [BUCKET_NBITS-1:0]      ekey_hash_table0_rdata,

  output logic                         ekey_hash_table1_rd,
  output logic [DEPTH_NBITS-1:0]       ekey_hash_table1_raddr,
  input  logic                         ekey_hash_table1_ack,
  input  logic [BUCKET_NBITS-1:0]      ekey_hash_table1_rdata,

  output logic                         ekey_value_rd,
  output logic [VALUE_DEPTH_NBITS-1:0] ekey_value_raddr,
  input  logic                         ekey_value_ack,
  input  logic [VALUE_NBITS-1:0]       ekey_value_rdata,

  output logic                         ekey_value_wr,
  output logic [VALUE_DEPTH_NBITS-1:0] ekey_value_waddr,
  output logic [WM_NBITS-1:0]          ekey_value_wdata,

  output logic [31:0]                  lookup_cnt,
  output logic [31:0]                  hit_cnt
);

  localparam int NCHUNK    = (KEY_NBITS + DEPTH_NBITS - 1) / DEPTH_NBITS;
  localparam int PAD_NBITS = NCHUNK * DEPTH_NBITS;

  typedef enum logic [2:0] {
    StIdle, StBktRd, StBktWait, StCmp, StValRd, StValWait, StWrbk, StResp
  } state_e;

  state_e state_q, state_d;

  logic [KEY_NBITS-1:0]         key_q;
  logic [DEPTH_NBITS-1:0]       h0_q, h1_q;
  logic                         got0_q, got1_q;
  logic [BUCKET_NBITS-1:0]      bkt0_q, bkt1_q;
  logic                         hit_q;
  logic [VALUE_DEPTH_NBITS-1:0] ptr_q;
  logic [VALUE_NBITS-1:0]       val_q;
  logic [31:0]                  lookup_cnt_q, hit_cnt_q;

  logic                         cmp_hit;
  logic [VALUE_DEPTH_NBITS-1:0] cmp_ptr;
  logic [ENTRY_NBITS-1:0]       ent [4];
  logic [31:0]                  cnt_low;
  logic                         bkt_done;

  function automatic logic [DEPTH_NBITS-1:0] fold(input logic [KEY_NBITS-1:0] k);
    logic [PAD_NBITS-1:0]   p;
    logic [DEPTH_NBITS-1:0] r;
    p = '0;
    p[KEY_NBITS-1:0] = k;
    r = '0;
    for (int i = 0; i < NCHUNK; i++) r = r ^ p[i*DEPTH_NBITS +: DEPTH_NBITS];
    return r;
  endfunction

  function automatic logic [KEY_NBITS-1:0] bit_rev(input logic [KEY_NBITS-1:0] k);
    logic [KEY_NBITS-1:0] r;
    for (int i = 0; i < KEY_NBITS; i++) r[i] = k[KEY_NBITS-1-i];
    return r;
  endfunction

  // Candidate order t0.e0, t0.e1, t1.e0, t1.e1; scanning downwards lets the lowest index win.
  always_comb begin
    ent[0]  = bkt0_q[0 +: ENTRY_NBITS];
    ent[1]  = bkt0_q[ENTRY_NBITS +: ENTRY_NBITS];
    ent[2]  = bkt1_q[0 +: ENTRY_NBITS];
    ent[3]  = bkt1_q[ENTRY_NBITS +: ENTRY_NBITS];
    cmp_hit = 1'b0;
    cmp_ptr = '0;
    for (int i = 3; i >= 0; i--) begin
      if (ent[i][ENTRY_NBITS-1] && (ent[i][ENTRY_NBITS-2 -: KEY_NBITS] == key_q)) begin
        cmp_hit = 1'b1;
        cmp_ptr = ent[i][VALUE_DEPTH_NBITS-1:0];
      end
    end
  end

  assign bkt_done = (got0_q | ekey_hash_table0_ack) & (got1_q | ekey_hash_table1_ack);
  assign cnt_low  = (val_q[31:0] == 32'hFFFF_FFFF) ? val_q[31:0] : val_q[31:0] + 32'd1;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (req_valid) state_d = StBktRd;
      StBktRd:   state_d = StBktWait;
      StBktWait: if (bkt_done) state_d = StCmp;
      StCmp:     state_d = cmp_hit ? StValRd : StResp;
      StValRd:   state_d = StValWait;
      StValWait: if (ekey_value_ack) state_d = StWrbk;
      StWrbk:    state_d = StResp;
      StResp:    if (resp_ready) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!`RESET_SIG) state_q <= StIdle;
    else             state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!`RESET_SIG) begin
      key_q        <= '0;
      h0_q         <= '0;
      h1_q         <= '0;
      got0_q       <= 1'b0;
      got1_q       <= 1'b0;
      bkt0_q       <= '0;
      bkt1_q       <= '0;
      hit_q        <= 1'b0;
      ptr_q        <= '0;
      val_q        <= '0;
      lookup_cnt_q <= '0;
      hit_cnt_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            key_q  <= req_key;
            h0_q   <= fold(req_key);
            h1_q   <= fold(bit_rev(req_key));
            got0_q <= 1'b0;
            got1_q <= 1'b0;
            hit_q  <= 1'b0;
            ptr_q  <= '0;
            val_q  <= '0;
            if (lookup_cnt_q != 32'hFFFF_FFFF) lookup_cnt_q <= lookup_cnt_q + 32'd1;
          end
        end
        StBktWait: begin
          if (ekey_hash_table0_ack) begin
            bkt0_q <= ekey_hash_table0_rdata;
            got0_q <= 1'b1;
          end
          if (ekey_hash_table1_ack) begin
            bkt1_q <= ekey_hash_table1_rdata;
            got1_q <= 1'b1;
          end
        end
        StCmp: begin
          if (cmp_hit) begin
            hit_q <= 1'b1;
            ptr_q <= cmp_ptr;
          end
        end
        StValWait: begin
          if (ekey_value_ack) val_q <= ekey_value_rdata;
        end
        StWrbk: begin
          if (hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_q <= hit_cnt_q + 32'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    req_ready              = (state_q == StIdle);
    resp_valid             = (state_q == StResp);
    resp_hit               = hit_q;
    resp_ptr               = ptr_q;
    resp_value             = val_q;
    ekey_hash_table0_rd    = (state_q == StBktRd);
    ekey_hash_table1_rd    = (state_q == StBktRd);
    ekey_hash_table0_raddr = h0_q;
    ekey_hash_table1_raddr = h1_q;
    ekey_value_rd          = (state_q == StValRd);
    ekey_value_raddr       = ptr_q;
    ekey_value_wr          = (state_q == StWrbk);
    ekey_value_waddr       = ptr_q;
    ekey_value_wdata       = '0;
    if (state_q == StWrbk) ekey_value_wdata = {val_q[WM_NBITS-1:32], cnt_low};
    lookup_cnt             = lookup_cnt_q;
    hit_cnt                = hit_cnt_q;
  end

endmodule

// File: tb/tb_decap_ekey_lookup.sv
// Bench for decap_ekey_lookup: directed vector table, reset/back-pressure sequences and
// randomized lookups against behavioural table/value memories.
`ifndef EKEY_HASH_TABLE_DEPTH_NBITS
`define EKEY_HASH_TABLE_DEPTH_NBITS 8
`endif
`ifndef EKEY_VALUE_DEPTH_NBITS
`define EKEY_VALUE_DEPTH_NBITS 10
`endif
`ifndef EKEY_VALUE_NBITS
`define EKEY_VALUE_NBITS 128
`endif
`ifndef RESET_SIG
`define RESET_SIG rst_n
`endif

module tb_decap_ekey_lookup;
  localparam int K  = 64;
  localparam int D  = `EKEY_HASH_TABLE_DEPTH_NBITS;
  localparam int VD = `EKEY_VALUE_DEPTH_NBITS;
  localparam int VN = `EKEY_VALUE_NBITS;
  localparam int E  = 1 + K + VD;
  localparam int B  = 2 * E;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          req_valid = 1'b0, req_ready;
  logic [K-1:0]  req_key = '0;
  logic          resp_valid, resp_ready = 1'b0, resp_hit;
  logic [VD-1:0] resp_ptr;
  logic [VN-1:0] resp_value;
  logic          t0_rd, t1_rd, t0_ack = 1'b0, t1_ack = 1'b0;
  logic [D-1:0]  t0_raddr, t1_raddr;
  logic [B-1:0]  t0_rdata = '0, t1_rdata = '0;
  logic          v_rd, v_ack = 1'b0, v_wr;
  logic [VD-1:0] v_raddr, v_waddr;
  logic [VN-1:0] v_rdata = '0;
  logic [63:0]   v_wdata;
  logic [31:0]   lookup_cnt, hit_cnt;

  decap_ekey_lookup dut (
    .clk                    (clk),
    .`RESET_SIG             (rst_n),
    .req_valid              (req_valid),
    .req_key                (req_key),
    .req_ready              (req_ready),
    .resp_valid             (resp_valid),
    .resp_ready             (resp_ready),
    .resp_hit               (resp_hit),
    .resp_ptr               (resp_ptr),
    .resp_value             (resp_value),
    .ekey_hash_table0_rd    (t0_rd),
    .ekey_hash_table0_raddr (t0_raddr),
    .ekey_hash_table0_ack   (t0_ack),
    .ekey_hash_table0_rdata (t0_rdata),
    .ekey_hash_table1_rd    (t1_rd),
    .ekey_hash_table1_raddr (t1_raddr),
    .ekey_hash_table1_ack   (t1_ack),
    .ekey_hash_table1_rdata (t1_rdata),
    .ekey_value_rd          (v_rd),
    .ekey_value_raddr       (v_raddr),
    .ekey_value_ack         (v_ack),
    .ekey_value_rdata       (v_rdata),
    .ekey_value_wr          (v_wr),
    .ekey_value_waddr       (v_waddr),
    .ekey_value_wdata       (v_wdata),
    .lookup_cnt             (lookup_cnt),
    .hit_cnt                (hit_cnt)
  );

  // Behavioural memories and responder state
  logic [B-1:0]  tbl0 [2**D];
  logic [B-1:0]  tbl1 [2**D];
  logic [VN-1:0] vmem [2**VD];
  int d0 = 1, d1 = 1, dv = 1;
  int p0 = 0, p1 = 0, pv = 0;
  logic [D-1:0]  a0, a1;
  logic [VD-1:0] va, wr_addr;
  logic [63:0]   wr_data;
  int n_rd0, n_rd1, n_vrd, n_wr;
  int checks = 0, failures = 0;
  int exp_lk = 0, exp_hc = 0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory responders: ack arrives d cycles after the rd strobe, for exactly one cycle.
  initial begin
    forever begin
      @(negedge clk);
      t0_ack = 1'b0; t1_ack = 1'b0; v_ack = 1'b0;
      if (p0 > 0) begin p0--; if (p0 == 0) begin t0_ack = 1'b1; t0_rdata = tbl0[a0]; end end
      if (p1 > 0) begin p1--; if (p1 == 0) begin t1_ack = 1'b1; t1_rdata = tbl1[a1]; end end
      if (pv > 0) begin pv--; if (pv == 0) begin v_ack = 1'b1; v_rdata = vmem[va]; end end
      if (t0_rd) begin n_rd0++; a0 = t0_raddr; p0 = d0; end
      if (t1_rd) begin n_rd1++; a1 = t1_raddr; p1 = d1; end
      if (v_rd)  begin n_vrd++; va = v_raddr; pv = dv; end
      if (v_wr) begin
        n_wr++; wr_addr = v_waddr; wr_data = v_wdata;
        vmem[v_waddr][63:0] = v_wdata;
      end
    end
  end

  function automatic logic [D-1:0] m_hash(input logic [63:0] k, input bit rev);
    logic [63:0]  x;
    logic [D-1:0] h;
    x = k;
    if (rev) for (int i = 0; i < 64; i++) x[i] = k[63-i];
    h = '0;
    while (x != 0) begin
      h = h ^ x[D-1:0];
      x = x >> D;
    end
    return h;
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 2**D; i++) begin tbl0[i] = '0; tbl1[i] = '0; end
    for (int i = 0; i < 2**VD; i++) vmem[i] = '0;
  endtask

  // slot: 0=t0.e0 1=t0.e1 2=t1.e0 3=t1.e1, placed in the bucket the lookup key hashes to
  task automatic put(input logic [63:0] lkey, input int slot, input logic v,
                     input logic [63:0] k, input logic [VD-1:0] p);
    logic [E-1:0] ent;
    ent = {v, k, p};
    if (slot < 2) tbl0[m_hash(lkey, 0)][(slot % 2)*E +: E] = ent;
    else          tbl1[m_hash(lkey, 1)][(slot % 2)*E +: E] = ent;
  endtask

  task automatic model(input logic [63:0] key, output logic hit, output logic [VD-1:0] ptr);
    logic [B-1:0] bkt;
    logic [E-1:0] ent;
    hit = 1'b0; ptr = '0;
    for (int s = 0; s < 4 && !hit; s++) begin
      bkt = (s < 2) ? tbl0[m_hash(key, 0)] : tbl1[m_hash(key, 1)];
      ent = E'(bkt >> ((s % 2) * E));
      if (ent[E-1] == 1'b1 && ent[E-2 -: K] == key) begin hit = 1'b1; ptr = ent[VD-1:0]; end
    end
  endtask

  function automatic logic [63:0] bump(input logic [VN-1:0] v);
    logic [32:0] lo;
    lo = {1'b0, v[31:0]} + 33'd1;
    if (lo[32]) lo = 33'h0_FFFF_FFFF;
    return {v[63:32], lo[31:0]};
  endfunction

  task automatic do_lookup(input logic [63:0] key, input int hold, input logic eh,
                           input logic [VD-1:0] ep, input logic [VN-1:0] ev,
                           input logic [63:0] ew, input string tag);
    int lat, elat;
    elat = ((d0 > d1) ? d0 : d1) + 3 + (eh ? dv + 2 : 0);
    n_rd0 = 0; n_rd1 = 0; n_vrd = 0; n_wr = 0;
    @(negedge clk);
    check({tag, ".req_ready"}, req_ready, 1);
    req_valid = 1'b1; req_key = key;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!resp_valid && lat < 300);
    check({tag, ".latency"}, lat, elat);
    check({tag, ".resp"}, {resp_hit, resp_ptr, resp_value}, {eh, ep, ev});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, ".hold"}, {resp_valid, req_ready, resp_hit, resp_ptr, resp_value},
            {1'b1, 1'b0, eh, ep, ev});
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    @(negedge clk);
    check({tag, ".back_idle"}, {req_ready, resp_valid}, 2'b10);
    exp_lk++;
    if (eh) exp_hc++;
    check({tag, ".tbl_rd"}, {n_rd0[7:0], n_rd1[7:0], a0, a1},
          {8'd1, 8'd1, m_hash(key, 0), m_hash(key, 1)});
    check({tag, ".val_strobes"}, {n_vrd[7:0], n_wr[7:0]}, {7'd0, eh, 7'd0, eh});
    if (eh) check({tag, ".wr"}, {va, wr_addr, wr_data}, {ep, ep, ew});
    check({tag, ".counters"}, {lookup_cnt, hit_cnt}, {exp_lk[31:0], exp_hc[31:0]});
  endtask

  typedef struct {
    logic [63:0]   key;
    int            slot_a;   // primary valid copy, -1 for none
    logic [VD-1:0] ptr_a;
    int            slot_b;   // second valid copy, lower priority
    logic [VD-1:0] ptr_b;
    int            inv_slot; // matching key with valid=0
    logic [31:0]   low;
    int            rd0, rd1, rdv, hold;
    logic          exp_hit;
    logic [VD-1:0] exp_ptr;
    logic [31:0]   exp_low;
  } vec_t;

  vec_t vecs[6];

  task automatic setup_vec(input vec_t v, output logic [VN-1:0] word);
    clear_mem();
    word = {$urandom, $urandom, $urandom, v.low};
    if (v.inv_slot >= 0) put(v.key, v.inv_slot, 1'b0, v.key, 10'd11);
    if (v.slot_a >= 0) begin put(v.key, v.slot_a, 1'b1, v.key, v.ptr_a); vmem[v.ptr_a] = word; end
    if (v.slot_b >= 0) begin
      put(v.key, v.slot_b, 1'b1, v.key, v.ptr_b);
      vmem[v.ptr_b] = ~word;
    end
    d0 = v.rd0; d1 = v.rd1; dv = v.rdv;
  endtask

  initial begin
    logic [VN-1:0] word, ev;
    logic          mh;
    logic [VD-1:0] mp;
    logic [63:0]   key;
    int            cyc;

    vecs[0] = '{64'h1234, -1, 0, -1, 0, -1, 32'h0, 1, 1, 1, 0, 1'b0, 0, 32'h0};
    vecs[1] = '{64'hA5A5_0000_1111_2222, 3, 5, -1, 0, -1, 32'h7, 1, 1, 1, 0, 1'b1, 5, 32'h8};
    vecs[2] = '{64'h0BAD_F00D_DEAD_BEEF, 1, 3, 2, 9, 0, 32'h100, 1, 1, 1, 0, 1'b1, 3, 32'h101};
    vecs[3] = '{64'h1357_9BDF_2468_ACE0, 0, 7, -1, 0, -1, 32'hFFFF_FFFF, 5, 1, 1, 0,
                1'b1, 7, 32'hFFFF_FFFF};
    vecs[4] = '{64'h0F0F_1E1E_2D2D_3C3C, 2, 12, -1, 0, -1, 32'h42, 1, 1, 2, 10, 1'b1, 12, 32'h43};
    vecs[5] = '{64'h7777_0000_8888_0001, -1, 0, -1, 0, 1, 32'h0, 2, 3, 1, 0, 1'b0, 0, 32'h0};

    clear_mem();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset.outputs", {req_ready, resp_valid, resp_hit, resp_ptr, resp_value},
          {1'b1, 1'b0, 1'b0, 10'd0, 128'd0});
    check("reset.strobes", {t0_rd, t1_rd, v_rd, v_wr, v_wdata, t0_raddr, t1_raddr},
          {4'b0, 64'd0, 8'd0, 8'd0});
    check("reset.counters", {lookup_cnt, hit_cnt}, 64'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      setup_vec(vecs[i], word);
      ev = vecs[i].exp_hit ? word : '0;
      do_lookup(vecs[i].key, vecs[i].hold, vecs[i].exp_hit, vecs[i].exp_ptr, ev,
                {word[63:32], vecs[i].exp_low}, $sformatf("vec%0d", i));
    end

    // Randomized lookups against the reference model
    for (int n = 0; n < 30; n++) begin
      clear_mem();
      key = {$urandom, $urandom};
      for (int s = 0; s < 4; s++) begin
        logic [VD-1:0] p;
        p = VD'($urandom);
        vmem[p] = {$urandom, $urandom, $urandom,
                   ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom};
        case ($urandom_range(0, 3))
          0: ;
          1: put(key, s, 1'b1, key ^ (64'd1 << $urandom_range(0, 63)), p);
          2: put(key, s, 1'b0, key, p);
          default: put(key, s, 1'b1, key, p);
        endcase
      end
      d0 = $urandom_range(1, 4); d1 = $urandom_range(1, 4); dv = $urandom_range(1, 4);
      model(key, mh, mp);
      ev = mh ? vmem[mp] : '0;
      do_lookup(key, $urandom_range(0, 3), mh, mp, ev, bump(ev), $sformatf("rnd%0d", n));
    end

    // Reset while waiting on the value read; the late ack must be ignored.
    setup_vec(vecs[1], word);
    dv = 6;
    n_rd0 = 0; n_rd1 = 0; n_vrd = 0; n_wr = 0;
    @(negedge clk);
    req_valid = 1'b1; req_key = vecs[1].key;
    @(posedge clk); #1;
    req_valid = 1'b0;
    cyc = 0;
    while (n_vrd == 0 && cyc < 50) begin @(negedge clk); cyc++; end
    check("rst_mid.val_rd_seen", n_vrd, 1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_mid.outputs", {req_ready, resp_valid, resp_hit, resp_ptr, resp_value},
          {1'b1, 1'b0, 1'b0, 10'd0, 128'd0});
    check("rst_mid.counters", {lookup_cnt, hit_cnt}, 64'd0);
    repeat (8) @(negedge clk);
    check("rst_mid.no_write", n_wr, 0);
    check("rst_mid.still_idle", {req_ready, resp_valid, v_wr, resp_value},
          {1'b1, 1'b0, 1'b0, 128'd0});
    exp_lk = 0; exp_hc = 0;
    setup_vec(vecs[0], word);
    do_lookup(vecs[0].key, 0, 1'b0, '0, '0, '0, "after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/decap_ekey_lookup.md
# decap_ekey_lookup

Lookup engine for the decap ekey tables: accepts a key from the decap pipeline, hashes it into both ekey hash tables, compares bucket entries, fetches the matching ekey value, and writes back an incremented hit counter in value word 0. It is the initiator side of the ekey memory block's application ports: it drives the hash-table read ports, the value read port and the value write port, and consumes their ack/rdata returns. It handles one request at a time behind a valid/ready request and response handshake.

## Interface
Parameters
- KEY_NBITS, 64: lookup key width.
- DEPTH_NBITS, `EKEY_HASH_TABLE_DEPTH_NBITS: hash-table index width.
- VALUE_DEPTH_NBITS, `EKEY_VALUE_DEPTH_NBITS: value pointer width.
- ENTRY_NBITS, 1+KEY_NBITS+VALUE_DEPTH_NBITS: one bucket entry, {valid, key, ptr}, with valid at the MSB.
- BUCKET_NBITS, 2*ENTRY_NBITS: two entries per bucket; entry 0 occupies the LSBs.
- VALUE_NBITS, `EKEY_VALUE_NBITS: full value width.
- WM_NBITS, 64: writable value word width (word 0).

Ports
- Clock and reset: one clock, `clk`; reset `` `RESET_SIG ``, synchronous, active-low.
- clk  in  1  core clock.
- `RESET_SIG  in  1  synchronous active-low reset.
- req_valid  in  1  lookup request valid.
- req_key  in  KEY_NBITS  key to look up.
- req_ready  out  1  high only in IDLE.
- resp_valid  out  1  response valid; held until resp_ready.
- resp_ready  in  1  response accepted.
- resp_hit  out  1  key found.
- resp_ptr  out  VALUE_DEPTH_NBITS  matching value pointer; 0 on miss.
- resp_value  out  VALUE_NBITS  value read before the increment; 0 on miss.
- ekey_hash_table0_rd / ekey_hash_table1_rd  out  1  one-cycle read pulse.
- ekey_hash_table0_raddr / ekey_hash_table1_raddr  out  DEPTH_NBITS  h0 / h1.
- ekey_hash_table0_ack / ekey_hash_table1_ack  in  1  bucket read return.
- ekey_hash_table0_rdata / ekey_hash_table1_rdata  in  BUCKET_NBITS  bucket data.
- ekey_value_rd  out  1  one-cycle read pulse.
- ekey_value_raddr  out  VALUE_DEPTH_NBITS  pointer to read.
- ekey_value_ack  in  1  value read return.
- ekey_value_rdata  in  VALUE_NBITS  value data.
- ekey_value_wr  out  1  one-cycle write pulse.
- ekey_value_waddr  out  VALUE_DEPTH_NBITS  pointer to write.
- ekey_value_wdata  out  WM_NBITS  updated word 0.
- lookup_cnt, hit_cnt  out  32  saturating statistics.

## Operation
- Hashes
  - h0 = XOR-fold of req_key in DEPTH_NBITS chunks, with the top chunk zero-padded.
  - h1 = the same fold applied to bit-reversed req_key.
  - Both are registered at accept.
- State machine
  - IDLE -> BKT_RD on req_valid&req_ready. The key and hashes are latched, and lookup_cnt is incremented.
  - BKT_RD: pulse both table rd signals with raddr = h0 / h1 -> BKT_WAIT.
  - BKT_WAIT: latch each table's rdata on its ack, tracked by flags got0/got1. Acks may arrive in either order or in the same cycle. Move to CMP the cycle after both flags are set.
  - CMP: an entry matches when valid=1 and its key equals the latched key.
    - Priority order: t0.e0, t0.e1, t1.e0, t1.e1. Duplicate matches resolve by this priority.
    - On a hit: latch ptr -> VAL_RD.
    - On a miss: -> RESP with resp_hit=0.
  - VAL_RD: pulse ekey_value_rd with raddr = ptr -> VAL_WAIT.
  - VAL_WAIT: on ekey_value_ack, capture rdata -> WRBK.
  - WRBK: pulse ekey_value_wr with waddr = ptr.
    - wdata = {rdata[63:32], sat32(rdata[31:0]+1)}; 0xFFFFFFFF stays 0xFFFFFFFF.
    - hit_cnt increments.
    - Next state RESP.
  - RESP: resp_valid=1 -> IDLE on resp_ready.
- Statistics: lookup_cnt and hit_cnt saturate at 0xFFFFFFFF.
- Acks outside BKT_WAIT / VAL_WAIT are ignored.
- Stall behaviour: the block waits indefinitely for acks; there is no timeout.

## Timing
- Reset values: all outputs 0, except req_ready=1 (IDLE). Counters 0, got flags 0.
- All rd/wr strobes are exactly one cycle wide; addresses are valid in the same cycle as the strobe.
- Worked latency, with memories acking 1 cycle after rd and the request accepted at T:
  - rd pulses at T+1, acks at T+2, CMP at T+3.
  - Miss: resp_valid at T+4.
  - Hit: value rd at T+4, ack at T+5, wr at T+6, resp_valid at T+7.
- Response back-pressure: resp_valid and resp data are held stable while resp_ready=0. req_ready rises the cycle after the response is accepted.
- Reset mid-operation:
  - The FSM returns to IDLE and the in-flight request is dropped.
  - No write is issued.
  - Late acks arriving after reset are ignored.

## Test plan
- Miss with empty tables (all valid=0), key 0x1234 -> resp_hit=0, resp_ptr=0, resp_value=0 at T+4; lookup_cnt=1, hit_cnt=0; no ekey_value_rd or ekey_value_wr.
- Hit in t1.e1 with ptr=5 and word0 low half=7 -> value rd at address 5; wr at address 5 with low half=8; resp_hit=1, resp_ptr=5, resp_value low half=7; hit_cnt=1.
- Same key valid in t0.e1 (ptr 3) and t1.e0 (ptr 9) -> resp_ptr=3; entries with valid=0 and a matching key do not hit.
- Acks skewed: table1 ack at T+2, table0 ack at T+6 -> CMP at T+7. Separately, word0 low half=0xFFFFFFFF -> wdata low half stays 0xFFFFFFFF.
- resp_ready held low for 10 cycles -> response held stable and req_ready=0 throughout. Reset asserted in VAL_WAIT, then a value ack delivered -> outputs at reset values and no ekey_value_wr pulse.
